// File: rtl/stm32_bus_engine_if.sv
// Byte-wide MCU bus between the STM32 and the FPGA: opcode strobe, input byte,
// and the FPGA's output byte with its drive enable.
interface stm32_bus_engine_if;
  logic       DATA_SYNC;
  logic [7:0] DATA_BUS_IN;
  logic [7:0] DATA_BUS_OUT;
  logic       DATA_BUS_OE;

  modport master (output DATA_SYNC, DATA_BUS_IN, input DATA_BUS_OUT, DATA_BUS_OE);
  modport slave  (input DATA_SYNC, DATA_BUS_IN, output DATA_BUS_OUT, DATA_BUS_OE);
endinterface

// File: rtl/stm32_bus_engine.sv
// MCU parallel-bus command engine: opcode decode, RX IQ FIFO with overflow and
// underflow accounting, atomic parameter block load and TX IQ delivery.
module stm32_bus_engine #(
  parameter int                         SAMPLE_WIDTH = 16,
  parameter int                         FIFO_AW      = 3,
  parameter int                         PARAM_BYTES  = 16,
  parameter int                         RX_BURST     = 1,
  parameter logic [8*PARAM_BYTES-1:0]   PARAM_RESET  = '0
) (
  input  logic                           clk_in,
  input  logic                           reset_n,
  stm32_bus_engine_if.slave              bus,
  input  logic signed [SAMPLE_WIDTH-1:0] RX_I,
  input  logic signed [SAMPLE_WIDTH-1:0] RX_Q,
  input  logic                           IQ_valid,
  input  logic                           ADC_OTR,
  input  logic                           DAC_OTR,
  output logic signed [SAMPLE_WIDTH-1:0] TX_I,
  output logic signed [SAMPLE_WIDTH-1:0] TX_Q,
  output logic                           tx_iq_valid,
  output logic [8*PARAM_BYTES-1:0]       PARAMS,
  output logic                           params_valid,
  output logic [FIFO_AW:0]               fifo_level
);

  localparam int SB     = SAMPLE_WIDTH / 8;
  localparam int WW     = 2 * SAMPLE_WIDTH;
  localparam int DEPTH  = 1 << FIFO_AW;
  localparam int PB_M1  = PARAM_BYTES - 1;
  localparam int IQ_M1  = 2 * SB - 1;
  localparam int RXB_M1 = RX_BURST - 1;
  localparam logic [6:0]       LAST_PARAM = PB_M1[6:0];
  localparam logic [6:0]       LAST_IQ    = IQ_M1[6:0];
  localparam logic [FIFO_AW:0] LAST_BURST = RXB_M1[FIFO_AW:0];
  localparam logic [FIFO_AW:0] FULL_LEVEL = DEPTH[FIFO_AW:0];

  typedef enum logic [2:0] {S_IDLE, S_ECHO, S_WPAR, S_STAT, S_TXIQ, S_RXIQ} state_t;

  state_t             state_reg;
  logic [6:0]         slot_reg;
  logic [FIFO_AW:0]   burst_reg;
  logic [WW-9:0]      tx_sh_reg;
  logic [WW-1:0]      rx_sh_reg;
  logic [WW-1:0]      fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [7:0]         ovf_cnt_reg, unf_cnt_reg;
  logic               ovf_sticky_reg, unf_sticky_reg;

  logic [8*PARAM_BYTES-1:0] params_load;
  logic [WW-1:0]            tx_full, rd_data;
  logic [31:0]              level_ext;
  logic [7:0]               level_byte, status_byte;
  logic fifo_empty, fifo_full, pop_req, pop, push, ovf_evt, unf_evt, stat_clr, shadow_we;

  assign fifo_empty = (fifo_level == '0);
  assign fifo_full  = (fifo_level == FULL_LEVEL);
  assign pop_req    = (state_reg == S_RXIQ) && (slot_reg == 7'd0) && !bus.DATA_SYNC;
  assign pop        = pop_req && !fifo_empty;
  // A pop in the same slot frees the entry, so a push into a full FIFO still lands.
  assign push       = IQ_valid && (!fifo_full || pop);
  assign ovf_evt    = IQ_valid && !push;
  assign unf_evt    = pop_req && fifo_empty;
  assign stat_clr   = (state_reg == S_STAT) && (slot_reg == 7'd3) && !bus.DATA_SYNC;
  assign shadow_we  = (state_reg == S_WPAR) && !bus.DATA_SYNC;
  assign rd_data    = fifo_mem[rd_ptr_reg];
  assign tx_full    = {tx_sh_reg, bus.DATA_BUS_IN};
  assign level_ext  = 32'(fifo_level);
  assign level_byte = (level_ext > 32'd255) ? 8'hFF : level_ext[7:0];

  // The final parameter byte is taken straight from the bus so the block loads in one edge.
  for (genvar gi = 0; gi < PARAM_BYTES; gi++) begin : g_shadow
    if (gi < PARAM_BYTES - 1) begin : g_byte
      logic [7:0] byte_reg;
      always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n)
          byte_reg <= 8'h00;
        else if (shadow_we && slot_reg == 7'(gi))
          byte_reg <= bus.DATA_BUS_IN;
      end
      assign params_load[gi*8 +: 8] = byte_reg;
    end else begin : g_last
      assign params_load[gi*8 +: 8] = bus.DATA_BUS_IN;
    end
  end

  always_comb begin
    status_byte = 8'h00;
    case (slot_reg[1:0])
      2'd0:    status_byte = {ADC_OTR, DAC_OTR, ovf_sticky_reg, unf_sticky_reg,
                              fifo_empty, fifo_full, 2'b00};
      2'd1:    status_byte = level_byte;
      2'd2:    status_byte = ovf_cnt_reg;
      default: status_byte = unf_cnt_reg;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (push)
      fifo_mem[wr_ptr_reg] <= {RX_Q, RX_I};
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_level     <= '0;
      ovf_cnt_reg    <= 8'h00;
      unf_cnt_reg    <= 8'h00;
      ovf_sticky_reg <= 1'b0;
      unf_sticky_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      // Clearing on the last status byte keeps any event from that same slot.
      if (stat_clr) begin
        ovf_cnt_reg    <= {7'd0, ovf_evt};
        unf_cnt_reg    <= {7'd0, unf_evt};
        ovf_sticky_reg <= ovf_evt;
        unf_sticky_reg <= unf_evt;
      end else begin
        if (ovf_evt) begin
          ovf_sticky_reg <= 1'b1;
          if (ovf_cnt_reg != 8'hFF) ovf_cnt_reg <= ovf_cnt_reg + 8'd1;
        end
        if (unf_evt) begin
          unf_sticky_reg <= 1'b1;
          if (unf_cnt_reg != 8'hFF) unf_cnt_reg <= unf_cnt_reg + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= S_IDLE;
      slot_reg         <= 7'd0;
      burst_reg        <= '0;
      tx_sh_reg        <= '0;
      rx_sh_reg        <= '0;
      bus.DATA_BUS_OUT <= 8'h00;
      bus.DATA_BUS_OE  <= 1'b0;
      TX_I             <= '0;
      TX_Q             <= '0;
      tx_iq_valid      <= 1'b0;
      PARAMS           <= PARAM_RESET;
      params_valid     <= 1'b0;
    end else begin
      tx_iq_valid  <= 1'b0;
      params_valid <= 1'b0;
      if (bus.DATA_SYNC) begin
        slot_reg        <= 7'd0;
        burst_reg       <= '0;
        bus.DATA_BUS_OE <= 1'b0;
        case (bus.DATA_BUS_IN)
          8'h00:   state_reg <= S_ECHO;
          8'h01:   state_reg <= S_WPAR;
          8'h02: begin state_reg <= S_STAT; bus.DATA_BUS_OE <= 1'b1; end
          8'h03:   state_reg <= S_TXIQ;
          8'h04: begin state_reg <= S_RXIQ; bus.DATA_BUS_OE <= 1'b1; end
          default: state_reg <= S_IDLE;
        endcase
      end else begin
        case (state_reg)
          S_ECHO: begin
            bus.DATA_BUS_OUT <= bus.DATA_BUS_IN;
            bus.DATA_BUS_OE  <= 1'b1;
            state_reg        <= S_IDLE;
          end
          S_WPAR: begin
            if (slot_reg == LAST_PARAM) begin
              PARAMS       <= params_load;
              params_valid <= 1'b1;
              state_reg    <= S_IDLE;
            end else begin
              slot_reg <= slot_reg + 7'd1;
            end
          end
          S_STAT: begin
            bus.DATA_BUS_OUT <= status_byte;
            if (slot_reg == 7'd3) state_reg <= S_IDLE;
            else                  slot_reg  <= slot_reg + 7'd1;
          end
          S_TXIQ: begin
            tx_sh_reg <= tx_full[WW-9:0];
            if (slot_reg == LAST_IQ) begin
              TX_Q        <= tx_full[WW-1:SAMPLE_WIDTH];
              TX_I        <= tx_full[SAMPLE_WIDTH-1:0];
              tx_iq_valid <= 1'b1;
              state_reg   <= S_IDLE;
            end else begin
              slot_reg <= slot_reg + 7'd1;
            end
          end
          S_RXIQ: begin
            if (slot_reg == 7'd0) begin
              bus.DATA_BUS_OUT <= fifo_empty ? 8'h00 : rd_data[WW-1 -: 8];
              rx_sh_reg        <= fifo_empty ? '0 : {rd_data[WW-9:0], 8'h00};
            end else begin
              bus.DATA_BUS_OUT <= rx_sh_reg[WW-1 -: 8];
              rx_sh_reg        <= {rx_sh_reg[WW-9:0], 8'h00};
            end
            if (slot_reg == LAST_IQ) begin
              slot_reg <= 7'd0;
              if (burst_reg == LAST_BURST) state_reg <= S_IDLE;
              else                         burst_reg <= burst_reg + 1'b1;
            end else begin
              slot_reg <= slot_reg + 7'd1;
            end
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

endmodule
